// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage.
// Owns the fetch PC, issues in-order word requests to instruction memory over
// a valid/ready channel with variable response latency, buffers returned words
// in a small FIFO and presents them to decode with PC and PC+4. Redirects flush
// the FIFO and turn every in-flight request into a discard credit.
// Optional build macro FETCH_MISALIGN_TRAP_EN: adds fetch_misaligned; a redirect
// to a non-word-aligned target sets it sticky and halts fetch. Without the macro
// the low two target bits are forced to zero.
module fetch_unit #(
   parameter logic [31:0] RESET_PC        = 32'h0000_0000,
   parameter int unsigned BUF_DEPTH       = 2,
   parameter int unsigned MAX_OUTSTANDING = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        pc_src,
   input  logic [31:0] pc_target,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_addr,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
`ifdef FETCH_MISALIGN_TRAP_EN
   output logic [31:0] instr_pc_plus4,
   output logic        fetch_misaligned
`else
   output logic [31:0] instr_pc_plus4
`endif
);

   localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);
   localparam int unsigned OST_W = $clog2(MAX_OUTSTANDING + 1);

   logic [31:0]      fetch_pc_q, fetch_pc_d;
   logic [31:0]      resp_pc_q, resp_pc_d;
   logic [31:0]      buf_data_q [BUF_DEPTH];
   logic [31:0]      buf_data_d [BUF_DEPTH];
   logic [31:0]      buf_pc_q   [BUF_DEPTH];
   logic [31:0]      buf_pc_d   [BUF_DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [OST_W-1:0] inflight_q, inflight_d;
   logic [OST_W-1:0] discard_q, discard_d;
   logic             halted_q;

   logic             accept;
   logic             push;
   logic             pop;
   logic [31:0]      redirect_pc;
   logic [31:0]      credit_used;

   // Request issue: blocked during redirect, on halt, at the outstanding limit,
   // or when buffered plus live in-flight words would overrun the FIFO.
   always_comb begin
      credit_used    = 32'(count_q) + 32'(inflight_q) - 32'(discard_q);
      imem_req_valid = !reset && !pc_src && !halted_q
                       && (32'(inflight_q) < MAX_OUTSTANDING)
                       && (credit_used < BUF_DEPTH);
   end

   assign imem_addr = fetch_pc_q;

   // Handshake qualifiers and the effective redirect address.
   always_comb begin
      accept      = imem_req_valid && imem_req_ready;
      push        = imem_resp_valid && (discard_q == '0) && !pc_src;
      pop         = instr_valid && instr_ready && !pc_src;
      redirect_pc = pc_target;
`ifndef FETCH_MISALIGN_TRAP_EN
      redirect_pc[1:0] = 2'b00;
`endif
   end

   // Next-state for PCs, FIFO and the in-flight/discard bookkeeping.
   always_comb begin
      fetch_pc_d = fetch_pc_q;
      resp_pc_d  = resp_pc_q;
      buf_data_d = buf_data_q;
      buf_pc_d   = buf_pc_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      discard_d  = discard_q;
      inflight_d = inflight_q + OST_W'(accept) - OST_W'(imem_resp_valid);
      count_d    = count_q + CNT_W'(push) - CNT_W'(pop);

      if (imem_resp_valid && (discard_q != '0)) begin
         discard_d = discard_q - OST_W'(1);
      end

      if (accept) begin
         fetch_pc_d = fetch_pc_q + 32'd4;
      end

      if (push) begin
         buf_data_d[wr_ptr_q] = imem_resp_data;
         buf_pc_d[wr_ptr_q]   = resp_pc_q;
         wr_ptr_d             = wr_ptr_q + PTR_W'(1);
         resp_pc_d            = resp_pc_q + 32'd4;
      end

      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end

      // Redirect: flush, restart both PCs, and mark every request still in
      // flight after this cycle's response as one to drop.
      if (pc_src) begin
         fetch_pc_d = redirect_pc;
         resp_pc_d  = redirect_pc;
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         count_d    = '0;
         discard_d  = inflight_d;
      end
   end

`ifdef FETCH_MISALIGN_TRAP_EN
   logic halted_d;

   // Sticky trap on a redirect to a misaligned target.
   always_comb begin
      halted_d = halted_q;
      if (pc_src && (pc_target[1:0] != 2'b00)) begin
         halted_d = 1'b1;
      end
   end

   // Trap flag register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         halted_q <= 1'b0;
      end else begin
         halted_q <= halted_d;
      end
   end

   assign fetch_misaligned = halted_q;
`else
   assign halted_q = 1'b0;
`endif

   // State registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetch_pc_q <= RESET_PC;
         resp_pc_q  <= RESET_PC;
         buf_data_q <= '{default: '0};
         buf_pc_q   <= '{default: '0};
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         inflight_q <= '0;
         discard_q  <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         resp_pc_q  <= resp_pc_d;
         buf_data_q <= buf_data_d;
         buf_pc_q   <= buf_pc_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         inflight_q <= inflight_d;
         discard_q  <= discard_d;
      end
   end

   // Decode-facing view of the FIFO head; fields read as zero when empty.
   always_comb begin
      instr_valid = (count_q != '0);
      instr       = '0;
      instr_pc    = '0;
      if (instr_valid) begin
         instr    = buf_data_q[rd_ptr_q];
         instr_pc = buf_pc_q[rd_ptr_q];
      end
      instr_pc_plus4 = instr_pc + 32'd4;
   end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit with a transaction-level model
// (outstanding-request queue with stale tags, expected-PC FIFO) and a
// variable-latency in-order memory.
module tb_fetch_unit;

   localparam int unsigned DEPTH = 2;
   localparam int unsigned MAXO  = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        pc_src;
   logic [31:0] pc_target;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_addr;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic [31:0] instr_pc_plus4;
`ifdef FETCH_MISALIGN_TRAP_EN
   logic        fetch_misaligned;
`endif

   always #5 clk = ~clk;

   fetch_unit #(
      .RESET_PC        (32'h0000_0000),
      .BUF_DEPTH       (DEPTH),
      .MAX_OUTSTANDING (MAXO)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .pc_src          (pc_src),
      .pc_target       (pc_target),
      .imem_req_valid  (imem_req_valid),
      .imem_req_ready  (imem_req_ready),
      .imem_addr       (imem_addr),
      .imem_resp_valid (imem_resp_valid),
      .imem_resp_data  (imem_resp_data),
      .instr_valid     (instr_valid),
      .instr_ready     (instr_ready),
      .instr           (instr),
      .instr_pc        (instr_pc),
`ifdef FETCH_MISALIGN_TRAP_EN
      .instr_pc_plus4  (instr_pc_plus4),
      .fetch_misaligned(fetch_misaligned)
`else
      .instr_pc_plus4  (instr_pc_plus4)
`endif
   );

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   int lat      = 1;

   bit          s_pc_src;
   bit          s_iready;
   bit          s_mready;
   logic [31:0] s_tgt;

   logic [31:0] mem_addr [$];
   int          mem_due  [$];
   logic [31:0] os_addr  [$];
   bit          os_stale [$];
   logic [31:0] m_fifo   [$];
   logic [31:0] m_fetch_pc;
   bit          m_halted;

   logic [31:0] pop_log [$];
   logic [31:0] acc_log [$];
   int          first_req_cyc;
   int          first_valid_cyc;
   logic [31:0] first_pc;
   logic [31:0] first_p4;

   function automatic logic [31:0] word_at(input logic [31:0] a);
      return (a ^ 32'hC0DE_0000) + 32'h0000_0013;
   endfunction

   function automatic int live_count();
      int n = 0;
      foreach (os_stale[i]) if (!os_stale[i]) n++;
      return n;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
   endtask

   // One clock cycle: called at a negedge, returns at the next negedge.
   task automatic step();
      bit          resp_now;
      bit          exp_rv;
      bit          do_push;
      logic [31:0] ra;
      logic [31:0] head;
      cyc++;
      pc_src         = s_pc_src;
      pc_target      = s_tgt;
      instr_ready    = s_iready;
      imem_req_ready = s_mready;
      resp_now        = (mem_addr.size() != 0) && (mem_due[0] <= cyc);
      imem_resp_valid = resp_now;
      imem_resp_data  = resp_now ? word_at(mem_addr[0]) : 32'h0;
      #1;
      exp_rv = !s_pc_src && !m_halted && (os_addr.size() < int'(MAXO))
               && ((m_fifo.size() + live_count()) < int'(DEPTH));
      check("req_valid", 32'(imem_req_valid), 32'(exp_rv));
      if (exp_rv && imem_req_valid) check("imem_addr", imem_addr, m_fetch_pc);
      check("instr_valid", 32'(instr_valid), 32'(m_fifo.size() != 0));
      if ((m_fifo.size() != 0) && instr_valid) begin
         head = m_fifo[0];
         check("instr", instr, word_at(head));
         check("instr_pc", instr_pc, head);
         check("instr_pc_plus4", instr_pc_plus4, head + 32'd4);
      end
`ifdef FETCH_MISALIGN_TRAP_EN
      check("fetch_misaligned", 32'(fetch_misaligned), 32'(m_halted));
`endif
      // what the DUT actually did
      if (imem_req_valid && imem_req_ready) begin
         if (first_req_cyc < 0) first_req_cyc = cyc;
         acc_log.push_back(imem_addr);
      end
      if (instr_valid && (first_valid_cyc < 0)) begin
         first_valid_cyc = cyc;
         first_pc        = instr_pc;
         first_p4        = instr_pc_plus4;
      end
      if (instr_valid && instr_ready && !pc_src) pop_log.push_back(instr_pc);
      // memory
      if (resp_now) begin
         void'(mem_addr.pop_front());
         void'(mem_due.pop_front());
      end
      if (imem_req_valid && imem_req_ready) begin
         mem_addr.push_back(imem_addr);
         mem_due.push_back(cyc + lat);
      end
      // model
      do_push = 1'b0;
      ra      = 32'h0;
      if (resp_now) begin
         check("resp_has_request", 32'(os_addr.size() != 0), 32'd1);
         if (os_addr.size() != 0) begin
            ra = os_addr.pop_front();
            if (!os_stale.pop_front() && !s_pc_src) do_push = 1'b1;
         end
      end
      if ((m_fifo.size() != 0) && s_iready && !s_pc_src) void'(m_fifo.pop_front());
      if (do_push) m_fifo.push_back(ra);
      if (exp_rv && s_mready) begin
         os_addr.push_back(m_fetch_pc);
         os_stale.push_back(1'b0);
         m_fetch_pc += 32'd4;
      end
      if (s_pc_src) begin
         m_fifo.delete();
         foreach (os_stale[i]) os_stale[i] = 1'b1;
`ifdef FETCH_MISALIGN_TRAP_EN
         m_fetch_pc = s_tgt;
         if (s_tgt[1:0] != 2'b00) m_halted = 1'b1;
`else
         m_fetch_pc = {s_tgt[31:2], 2'b00};
`endif
      end
      @(negedge clk);
   endtask

   // Reset DUT, memory and model; called at a negedge, deasserts at a negedge.
   task automatic do_reset();
      reset           = 1'b1;
      pc_src          = 1'b0;
      pc_target       = 32'h0;
      imem_req_ready  = 1'b0;
      imem_resp_valid = 1'b0;
      imem_resp_data  = 32'h0;
      instr_ready     = 1'b0;
      s_pc_src = 1'b0; s_iready = 1'b0; s_mready = 1'b0; s_tgt = 32'h0;
      #1;
      check("rst_req_valid", 32'(imem_req_valid), 32'd0);
      check("rst_instr_valid", 32'(instr_valid), 32'd0);
      check("rst_instr", instr, 32'd0);
      check("rst_instr_pc", instr_pc, 32'd0);
`ifdef FETCH_MISALIGN_TRAP_EN
      check("rst_misaligned", 32'(fetch_misaligned), 32'd0);
`endif
      mem_addr.delete(); mem_due.delete();
      os_addr.delete();  os_stale.delete(); m_fifo.delete();
      pop_log.delete();  acc_log.delete();
      m_fetch_pc = 32'h0; m_halted = 1'b0; cyc = 0; lat = 1;
      first_req_cyc = -1; first_valid_cyc = -1; first_pc = 32'h0; first_p4 = 32'h0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int base;
      int accs;
      int k;
      int bad;
      reset = 1'b1;
      @(negedge clk);

      // 1-cycle memory, decode always ready
      do_reset();
      lat = 1; s_iready = 1'b1; s_mready = 1'b1;
      repeat (12) step();
      check("t1_acc0", acc_log[0], 32'h0);
      check("t1_acc1", acc_log[1], 32'h4);
      check("t1_acc2", acc_log[2], 32'h8);
      check("t1_first_latency", 32'(first_valid_cyc - first_req_cyc), 32'd2);
      check("t1_first_pc", first_pc, 32'h0);
      check("t1_first_pc4", first_p4, 32'h4);
      // two words of buffer credit with 1-cycle latency: 2 instructions per 3 cycles
      check("t1_pop_count", 32'(pop_log.size()), 32'd7);
      check("t1_pop3", pop_log[3], 32'hC);

      // decode stalled: only BUF_DEPTH words fetched, head stable
      do_reset();
      lat = 1; s_iready = 1'b0; s_mready = 1'b1;
      repeat (10) step();
      check("t2_acc_count", 32'(acc_log.size()), 32'd2);
      check("t2_no_pop", 32'(pop_log.size()), 32'd0);
      check("t2_head_pc", instr_pc, 32'h0);
      check("t2_req_blocked", 32'(imem_req_valid), 32'd0);
      s_iready = 1'b1;
      step();
      check("t2_req_after_pop", 32'(imem_req_valid), 32'd1);
      check("t2_addr_after_pop", imem_addr, 32'h8);
      check("t2_head_after_pop", instr_pc, 32'h4);

      // memory not ready: request and address held
      do_reset();
      lat = 1; s_iready = 1'b1; s_mready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         check("t3_hold_valid", 32'(imem_req_valid), 32'd1);
         check("t3_hold_addr", imem_addr, 32'h0);
      end
      s_mready = 1'b1;
      step();
      check("t3_addr_advanced", imem_addr, 32'h4);
      check("t3_acc_count", 32'(acc_log.size()), 32'd1);

      // redirect with 0x8 and 0xC in flight
      do_reset();
      lat = 3; s_iready = 1'b1; s_mready = 1'b1;
      k = 0;
      while ((acc_log.size() < 4) && (k < 30)) begin step(); k++; end
      check("t4_reached_0xC", acc_log[3], 32'hC);
      check("t4_two_in_flight", 32'(mem_addr.size()), 32'd2);
      s_pc_src = 1'b1; s_tgt = 32'h100;
      step();
      s_pc_src = 1'b0;
      check("t4_flushed", 32'(instr_valid), 32'd0);
      base = pop_log.size();
      repeat (20) step();
      check("t4_pop_a", pop_log[base], 32'h100);
      check("t4_pop_b", pop_log[base + 1], 32'h104);

      // redirect coinciding with a response, then a second redirect
      do_reset();
      lat = 2; s_iready = 1'b1; s_mready = 1'b1;
      k = 0;
      while (!((mem_addr.size() != 0) && (mem_due[0] <= cyc + 1) && (pop_log.size() >= 1))
             && (k < 20)) begin
         step(); k++;
      end
      check("t5_setup_found", 32'(k < 20), 32'd1);
      s_pc_src = 1'b1; s_tgt = 32'h100;
      step();
      s_tgt = 32'h200;
      step();
      s_pc_src = 1'b0;
      base = pop_log.size();
      repeat (20) step();
      check("t5_pop_a", pop_log[base], 32'h200);
      check("t5_pop_b", pop_log[base + 1], 32'h204);
      bad = 0;
      for (int i = base; i < pop_log.size(); i++)
         if ((pop_log[i] < 32'h200) || (pop_log[i] > 32'h2FC)) bad++;
      check("t5_stale_leak", 32'(bad), 32'd0);
      s_mready = 1'b0;
      repeat (8) step();
      check("t5_drained", 32'(mem_addr.size()), 32'd0);
      check("t5_req_resumes", 32'(imem_req_valid), 32'd1);

      // PC wrap-around
      do_reset();
      lat = 1; s_iready = 1'b1; s_mready = 1'b1;
      step();
      s_pc_src = 1'b1; s_tgt = 32'hFFFF_FFF8;
      step();
      s_pc_src = 1'b0;
      base = pop_log.size();
      repeat (16) step();
      check("t6_wrap0", pop_log[base],     32'hFFFF_FFF8);
      check("t6_wrap1", pop_log[base + 1], 32'hFFFF_FFFC);
      check("t6_wrap2", pop_log[base + 2], 32'h0000_0000);
      check("t6_wrap3", pop_log[base + 3], 32'h0000_0004);

      // misaligned redirect target
      do_reset();
      lat = 1; s_iready = 1'b1; s_mready = 1'b1;
      repeat (4) step();
      s_pc_src = 1'b1; s_tgt = 32'h102;
      step();
      s_pc_src = 1'b0;
      accs = acc_log.size();
      base = pop_log.size();
      repeat (10) step();
`ifdef FETCH_MISALIGN_TRAP_EN
      check("t7_trap_flag", 32'(fetch_misaligned), 32'd1);
      check("t7_no_requests", 32'(acc_log.size()), 32'(accs));
      check("t7_no_instr", 32'(instr_valid), 32'd0);
      check("t7_no_pops", 32'(pop_log.size()), 32'(base));
      do_reset();
      s_iready = 1'b1; s_mready = 1'b1;
      step();
      check("t7_fetch_after_reset", 32'(acc_log.size()), 32'd1);
`else
      check("t7_accs_resumed", 32'(acc_log.size() > accs), 32'd1);
      check("t7_aligned_a", pop_log[base], 32'h100);
      check("t7_aligned_b", pop_log[base + 1], 32'h104);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
